// File: rtl/k_and_s_pkg.sv
// Shared definitions for the K&S processor: instruction decode type, opcode
// values, ULA operation encodings and the flags bundle.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNOV,
    I_BNNEG,
    I_BNZERO,
    I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BOV    = 8'h05;
  localparam logic [7:0] OP_BNOV   = 8'h06;
  localparam logic [7:0] OP_BNNEG  = 8'h0A;
  localparam logic [7:0] OP_BNZERO = 8'h0B;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  localparam logic [1:0] ULA_OR  = 2'b00;
  localparam logic [1:0] ULA_ADD = 2'b01;
  localparam logic [1:0] ULA_SUB = 2'b10;
  localparam logic [1:0] ULA_AND = 2'b11;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ov;
    logic sov;
  } flags_t;

  function automatic decoded_instruction_type decode_opcode(input logic [7:0] opcode);
    decoded_instruction_type d;
    case (opcode)
      OP_LOAD:   d = I_LOAD;
      OP_STORE:  d = I_STORE;
      OP_MOVE:   d = I_MOVE;
      OP_ADD:    d = I_ADD;
      OP_SUB:    d = I_SUB;
      OP_AND:    d = I_AND;
      OP_OR:     d = I_OR;
      OP_BRANCH: d = I_BRANCH;
      OP_BZERO:  d = I_BZERO;
      OP_BNEG:   d = I_BNEG;
      OP_BOV:    d = I_BOV;
      OP_BNOV:   d = I_BNOV;
      OP_BNNEG:  d = I_BNNEG;
      OP_BNZERO: d = I_BNZERO;
      OP_HALT:   d = I_HALT;
      default:   d = I_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ks_ula.sv
// K&S ULA: combinational 16-bit OR/ADD/SUB/AND with zero, negative,
// unsigned-overflow (carry/borrow) and signed-overflow flags.
module ks_ula
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              ov,
  output logic              sov
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] add_ext;
  logic [DATA_W:0] sub_ext;

  // The extra top bit of the widened sum/difference is the carry/borrow.
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    result = '0;
    ov     = 1'b0;
    sov    = 1'b0;
    case (op)
      ULA_OR: result = a | b;
      ULA_ADD: begin
        result = add_ext[MSB:0];
        ov     = add_ext[DATA_W];
        sov    = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      ULA_SUB: begin
        result = sub_ext[MSB:0];
        ov     = sub_ext[DATA_W];
        sov    = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
      end
      ULA_AND: result = a & b;
      default: result = '0;
    endcase
    zero = (result == '0);
    neg  = result[MSB];
  end

endmodule

// File: rtl/datapath.sv
// K&S execution datapath: PC, IR, 4-entry register file, ULA and flags.
// Build option KS_R0_ZERO_EN hardwires R0 to zero.
module datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    reg_zero,
  output logic                    reg_neg,
  output logic                    reg_ov,
  output logic                    reg_sov,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  logic [ADDR_W-1:0]            pc_q, pc_d;
  logic [DATA_W-1:0]            ir_q, ir_d;
  logic [3:0][DATA_W-1:0]       regs_q, regs_d;
  flags_t                       flags_q, flags_d;

  logic [1:0]                   a_idx, b_idx, c_idx;
  logic [DATA_W-1:0]            a_val, b_val, wb_data;
  logic [DATA_W-1:0]            ula_result;
  logic                         ula_zero, ula_neg, ula_ov, ula_sov;

  // IR bit 7 carries no field in any instruction format.
  logic unused_ir_bit;
  assign unused_ir_bit = ir_q[7];

  always_comb begin
    decoded_instruction = decode_opcode(ir_q[15:8]);
    a_idx = ir_q[5:4];
    b_idx = ir_q[3:2];
    c_idx = ir_q[1:0];
    case (decoded_instruction)
      I_MOVE: begin
        // MOVE is executed as A | A, so both ULA operands read the source.
        a_idx = ir_q[3:2];
        b_idx = ir_q[3:2];
      end
      I_LOAD:  c_idx = ir_q[6:5];
      I_STORE: a_idx = ir_q[6:5];
      default: ;
    endcase
  end

`ifdef KS_R0_ZERO_EN
  assign a_val = (a_idx == 2'd0) ? '0 : regs_q[a_idx];
  assign b_val = (b_idx == 2'd0) ? '0 : regs_q[b_idx];
`else
  assign a_val = regs_q[a_idx];
  assign b_val = regs_q[b_idx];
`endif

  ks_ula #(
    .DATA_W (DATA_W)
  ) u_ula (
    .a      (a_val),
    .b      (b_val),
    .op     (operation),
    .result (ula_result),
    .zero   (ula_zero),
    .neg    (ula_neg),
    .ov     (ula_ov),
    .sov    (ula_sov)
  );

  assign wb_data  = c_sel ? ula_result : data_in;
  assign ram_addr = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
  assign data_out = a_val;

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    flags_d = flags_q;
    if (ir_enable) ir_d = data_in;
    if (pc_enable) pc_d = branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    if (write_reg_enable) begin
`ifdef KS_R0_ZERO_EN
      if (c_idx != 2'd0) regs_d[c_idx] = wb_data;
`else
      regs_d[c_idx] = wb_data;
`endif
    end
    if (flags_reg_enable) begin
      flags_d = '{zero: ula_zero, neg: ula_neg, ov: ula_ov, sov: ula_sov};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      ir_q    <= '0;
      // NOTE: the register file is only four words of flops, so it takes the
      // async reset like any other state; a RAM-based file would not.
      regs_q  <= '0;
      flags_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  assign reg_zero = flags_q.zero;
  assign reg_neg  = flags_q.neg;
  assign reg_ov   = flags_q.ov;
  assign reg_sov  = flags_q.sov;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus randomized ALU
// traffic compared against an arithmetic reference model.
module tb_datapath;
  import k_and_s_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    branch, pc_enable, ir_enable, write_reg_enable;
  logic                    addr_sel, c_sel, flags_reg_enable;
  logic [1:0]              operation;
  decoded_instruction_type decoded_instruction;
  logic                    reg_zero, reg_neg, reg_ov, reg_sov;
  logic [4:0]              ram_addr;
  logic [15:0]             data_out, data_in;

  int total = 0;
  int bad   = 0;

`ifdef KS_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  always #5 clk = ~clk;

  datapath dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .write_reg_enable    (write_reg_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .flags_reg_enable    (flags_reg_enable),
    .decoded_instruction (decoded_instruction),
    .reg_zero            (reg_zero),
    .reg_neg             (reg_neg),
    .reg_ov              (reg_ov),
    .reg_sov             (reg_sov),
    .ram_addr            (ram_addr),
    .data_out            (data_out),
    .data_in             (data_in)
  );

  // Reference model state.
  logic [4:0]  m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_regs [4];
  logic [3:0]  m_flags;  // {zero, neg, ov, sov}

  function automatic logic [15:0] mreg(input int k);
    if (R0_ZERO && k == 0) return 16'h0000;
    return m_regs[k];
  endfunction

  function automatic decoded_instruction_type mdecode(input logic [7:0] opc);
    case (opc)
      8'h81: return I_LOAD;   8'h82: return I_STORE;  8'h91: return I_MOVE;
      8'hA1: return I_ADD;    8'hA2: return I_SUB;    8'hA3: return I_AND;
      8'hA4: return I_OR;     8'h01: return I_BRANCH; 8'h02: return I_BZERO;
      8'h03: return I_BNEG;   8'h05: return I_BOV;    8'h06: return I_BNOV;
      8'h0A: return I_BNNEG;  8'h0B: return I_BNZERO; 8'hFF: return I_HALT;
      default: return I_NOP;
    endcase
  endfunction

  function automatic void mfields(input logic [15:0] ir, output int a, output int b,
                                  output int c);
    a = int'(ir[5:4]);
    b = int'(ir[3:2]);
    c = int'(ir[1:0]);
    if (ir[15:8] == 8'h91) begin a = int'(ir[3:2]); b = a; end
    if (ir[15:8] == 8'h81) c = int'(ir[6:5]);
    if (ir[15:8] == 8'h82) a = int'(ir[6:5]);
  endfunction

  // Returns {result, zero, neg, ov, sov} from integer arithmetic.
  function automatic logic [19:0] malu(input logic [15:0] a, input logic [15:0] b,
                                       input logic [1:0] op);
    int ua, ub, sa, sb, u, s;
    logic [15:0] res;
    logic o, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    o = 1'b0; v = 1'b0;
    case (op)
      2'b00: res = a | b;
      2'b01: begin
        u = ua + ub; s = sa + sb;
        res = u[15:0]; o = (u > 65535); v = (s > 32767) || (s < -32768);
      end
      2'b10: begin
        u = ua - ub; s = sa - sb;
        res = u[15:0]; o = (ua < ub); v = (s > 32767) || (s < -32768);
      end
      default: res = a & b;
    endcase
    return {res, (res == 16'h0000), res[15], o, v};
  endfunction

  task automatic model_reset();
    m_pc = '0; m_ir = '0; m_flags = '0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
  endtask

  // Applies one cycle of strobes, advances the model, returns to idle at edge+1.
  task automatic step(input logic br, input logic pe, input logic ie, input logic we,
                      input logic cs, input logic [1:0] op, input logic fe,
                      input logic [15:0] din);
    int a, b, c;
    logic [19:0] alu;
    logic [4:0]  n_pc;
    branch = br; pc_enable = pe; ir_enable = ie; write_reg_enable = we;
    c_sel = cs; operation = op; flags_reg_enable = fe; data_in = din;
    #1;
    mfields(m_ir, a, b, c);
    alu  = malu(mreg(a), mreg(b), op);
    n_pc = pe ? (br ? m_ir[4:0] : m_pc + 5'd1) : m_pc;
    @(posedge clk);
    #1;
    if (we && !(R0_ZERO && c == 0)) m_regs[c] = cs ? alu[19:4] : din;
    if (fe) m_flags = alu[3:0];
    if (ie) m_ir = din;
    m_pc = n_pc;
    branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
    c_sel = 0; flags_reg_enable = 0;
  endtask

  task automatic load_ir(input logic [15:0] w);
    step(0, 0, 1, 0, 0, 2'b00, 0, w);
  endtask

  task automatic set_reg(input logic [1:0] k, input logic [15:0] v);
    load_ir({8'h81, 1'b0, k, 5'd0});
    step(0, 0, 0, 1, 0, 2'b00, 0, v);
  endtask

  // Exposes register k on data_out through a STORE with A=k.
  task automatic peek(input logic [1:0] k);
    load_ir({8'h82, 1'b0, k, 5'd3});
  endtask

  task automatic exec_alu(input logic [1:0] op);
    step(0, 0, 0, 1, 1, op, 1, 16'h0000);
  endtask

  task automatic test_reset();
    step(0, 1, 1, 0, 0, 2'b00, 0, 16'h8165);
    set_reg(2'd1, 16'h8000);
    load_ir(16'hA114);
    step(0, 0, 0, 0, 0, 2'b01, 1, 16'h0000);
    rst_n = 0;
    addr_sel = 0;
    #1;
    model_reset();
    total++;
    if (decoded_instruction !== I_NOP) begin
      bad++; $display("FAIL reset_decode got=%s want=I_NOP", decoded_instruction.name());
    end
    total++;
    if ({reg_zero, reg_neg, reg_ov, reg_sov} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {reg_zero, reg_neg, reg_ov, reg_sov});
    end
    total++;
    if (ram_addr !== 5'd0 || data_out !== 16'h0000) begin
      bad++; $display("FAIL reset_bus got addr=%0d dout=%h want 0/0000", ram_addr, data_out);
    end
    addr_sel = 1;
    #1;
    total++;
    if (ram_addr !== 5'd0) begin
      bad++; $display("FAIL reset_ir_addr got=%0d want=0", ram_addr);
    end
    rst_n = 1;
    addr_sel = 0;
    #1;
  endtask

  task automatic test_load();
    step(0, 1, 1, 0, 0, 2'b00, 0, 16'h8165);
    addr_sel = 1; #1;
    total++;
    if (decoded_instruction !== I_LOAD || ram_addr !== 5'd5) begin
      bad++; $display("FAIL load_decode got=%s addr=%0d want=I_LOAD addr=5",
                      decoded_instruction.name(), ram_addr);
    end
    addr_sel = 0; #1;
    total++;
    if (ram_addr !== 5'd1) begin
      bad++; $display("FAIL load_pc got=%0d want=1", ram_addr);
    end
    step(0, 0, 0, 1, 0, 2'b00, 0, 16'h1234);
    peek(2'd3);
    total++;
    if (data_out !== 16'h1234) begin
      bad++; $display("FAIL load_r3 got=%h want=1234", data_out);
    end
  endtask

  task automatic test_add_overflow();
    set_reg(2'd1, 16'h7FFF);
    set_reg(2'd2, 16'h0001);
    load_ir(16'hA118);
    total++;
    if (decoded_instruction !== I_ADD) begin
      bad++; $display("FAIL add_decode got=%s want=I_ADD", decoded_instruction.name());
    end
    exec_alu(2'b01);
    total++;
    if ({reg_zero, reg_neg, reg_ov, reg_sov} !== 4'b0101 ||
        {reg_zero, reg_neg, reg_ov, reg_sov} !== m_flags) begin
      bad++; $display("FAIL add_flags got=%b want=0101", {reg_zero, reg_neg, reg_ov, reg_sov});
    end
    peek(2'd0);
    total++;
    if (data_out !== (R0_ZERO ? 16'h0000 : 16'h8000)) begin
      bad++; $display("FAIL add_r0 got=%h want=%h", data_out, R0_ZERO ? 16'h0000 : 16'h8000);
    end
  endtask

  task automatic test_sub_and();
    set_reg(2'd1, 16'h0000);
    set_reg(2'd2, 16'h0001);
    load_ir(16'hA218);
    exec_alu(2'b10);
    total++;
    if ({reg_zero, reg_neg, reg_ov, reg_sov} !== 4'b0110) begin
      bad++; $display("FAIL sub_flags got=%b want=0110", {reg_zero, reg_neg, reg_ov, reg_sov});
    end
    peek(2'd0);
    total++;
    if (data_out !== (R0_ZERO ? 16'h0000 : 16'hFFFF)) begin
      bad++; $display("FAIL sub_r0 got=%h want=%h", data_out, R0_ZERO ? 16'h0000 : 16'hFFFF);
    end
    load_ir(16'hA314);
    exec_alu(2'b11);
    total++;
    if ({reg_zero, reg_neg, reg_ov, reg_sov} !== 4'b1000) begin
      bad++; $display("FAIL and_flags got=%b want=1000", {reg_zero, reg_neg, reg_ov, reg_sov});
    end
  endtask

  task automatic test_pc_branch();
    load_ir(16'h001F);
    step(1, 1, 0, 0, 0, 2'b00, 0, 16'h0000);
    addr_sel = 0; #1;
    total++;
    if (ram_addr !== 5'd31) begin
      bad++; $display("FAIL pc_to_31 got=%0d want=31", ram_addr);
    end
    step(0, 1, 0, 0, 0, 2'b00, 0, 16'h0000);
    total++;
    if (ram_addr !== 5'd0) begin
      bad++; $display("FAIL pc_wrap got=%0d want=0", ram_addr);
    end
    load_ir(16'h0011);
    total++;
    if (decoded_instruction !== I_NOP) begin
      bad++; $display("FAIL nop_decode got=%s want=I_NOP", decoded_instruction.name());
    end
    step(1, 0, 0, 0, 0, 2'b00, 0, 16'h0000);
    total++;
    if (ram_addr !== 5'd0) begin
      bad++; $display("FAIL branch_no_pe got=%0d want=0", ram_addr);
    end
    step(1, 1, 0, 0, 0, 2'b00, 0, 16'h0000);
    total++;
    if (ram_addr !== 5'd17 || ram_addr !== m_pc) begin
      bad++; $display("FAIL branch_taken got=%0d want=17", ram_addr);
    end
  endtask

  task automatic test_store_r0();
    logic [15:0] v;
    v = 16'($urandom_range(1, 16'hFFFF));
    set_reg(2'd2, v);
    load_ir(16'h8243);
    addr_sel = 1; #1;
    total++;
    if (decoded_instruction !== I_STORE || ram_addr !== 5'd3 || data_out !== v) begin
      bad++; $display("FAIL store got=%s addr=%0d dout=%h want=I_STORE 3 %h",
                      decoded_instruction.name(), ram_addr, data_out, v);
    end
    addr_sel = 0;
    set_reg(2'd0, 16'hBEEF);
    peek(2'd0);
    total++;
    if (data_out !== (R0_ZERO ? 16'h0000 : 16'hBEEF)) begin
      bad++; $display("FAIL r0_write got=%h want=%h", data_out, R0_ZERO ? 16'h0000 : 16'hBEEF);
    end
  endtask

  task automatic test_back_to_back();
    set_reg(2'd1, 16'h0003);
    load_ir(16'hA115);
    exec_alu(2'b01);
    total++;
    if (data_out !== 16'h0006) begin
      bad++; $display("FAIL b2b_first got=%h want=0006", data_out);
    end
    exec_alu(2'b01);
    total++;
    if (data_out !== 16'h000C) begin
      bad++; $display("FAIL b2b_second got=%h want=000c", data_out);
    end
  endtask

  task automatic test_decode_all();
    int errs;
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      load_ir({i[7:0], 8'($urandom)});
      total++;
      if (decoded_instruction !== mdecode(i[7:0])) begin
        bad++; errs++;
        if (errs < 8)
          $display("FAIL decode op=%h got=%s want=%s", i[7:0],
                   decoded_instruction.name(), mdecode(i[7:0]).name());
      end
    end
  endtask

  task automatic test_random_alu();
    logic [7:0]  opc_tab [5];
    logic [1:0]  op_tab [5];
    int a, b, c, sel;
    opc_tab = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h91};
    op_tab  = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) set_reg(2'(i), 16'($urandom));
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) set_reg(2'($urandom), 16'($urandom));
      sel = $urandom_range(0, 4);
      load_ir({opc_tab[sel], 8'($urandom)});
      mfields(m_ir, a, b, c);
      total++;
      if (data_out !== mreg(a)) begin
        bad++; $display("FAIL rnd_read n=%0d got=%h want=%h", n, data_out, mreg(a));
      end
      exec_alu(op_tab[sel]);
      total++;
      if ({reg_zero, reg_neg, reg_ov, reg_sov} !== m_flags) begin
        bad++; $display("FAIL rnd_flags n=%0d ir=%h got=%b want=%b", n, m_ir,
                        {reg_zero, reg_neg, reg_ov, reg_sov}, m_flags);
      end
      peek(2'(c));
      total++;
      if (data_out !== mreg(c)) begin
        bad++; $display("FAIL rnd_result n=%0d got=%h want=%h", n, data_out, mreg(c));
      end
    end
  endtask

  initial begin
    rst_n = 0;
    branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
    addr_sel = 0; c_sel = 0; operation = 2'b00; flags_reg_enable = 0;
    data_in = 16'h0000;
    model_reset();
    #12;
    rst_n = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_add_overflow();
    test_sub_and();
    test_pc_branch();
    test_store_r0();
    test_back_to_back();
    test_decode_all();
    test_random_alu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
